// File: rtl/ooo_types.sv
// Shared out-of-order core types: physical register / ROB tag widths and the writeback entry.
// Also carries the mod-3 rotation helper used by the writeback round-robin pointer.
package ooo_types;

  localparam int PHYS_REG_BITS = 6;
  localparam int ROB_IDX_BITS  = 5;

  typedef enum logic [1:0] {
    SRC_ALU    = 2'd0,
    SRC_BRANCH = 2'd1,
    SRC_LSU    = 2'd2
  } wb_src_e;

  typedef struct packed {
    logic [PHYS_REG_BITS-1:0] preg;
    logic [31:0]              data;
    logic [ROB_IDX_BITS-1:0]  rob;
  } wb_entry_t;

  // (base + k) mod 3 for base, k in 0..2
  function automatic logic [1:0] rr_add(input logic [1:0] base, input logic [1:0] k);
    logic [2:0] s;
    s = {1'b0, base} + {1'b0, k};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// 2-entry result FIFO, 1 cycle push-to-head, registered count/head; push+pop together is legal even when full.
// Backpressure is the caller's job (push only when count<2 or popping); flush/reset empty it at the edge.
module wb_fifo
  import ooo_types::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  logic      pop,
  input  logic      flush,
  input  wb_entry_t din,
  output logic [1:0] count,
  output wb_entry_t head
);

  wb_entry_t  slot0;
  wb_entry_t  slot1;
  logic [1:0] cnt_q;
  logic       do_push;
  logic       do_pop;

  assign do_pop  = pop && (cnt_q != 2'd0);
  assign do_push = push && ((cnt_q != 2'd2) || do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      cnt_q <= 2'd0;
      slot0 <= '0;
      slot1 <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (cnt_q == 2'd0) slot0 <= din;
          else               slot1 <= din;
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          cnt_q <= cnt_q - 2'd1;
        end
        2'b11: begin
          // count unchanged; the new entry lands behind whatever remains
          if (cnt_q == 2'd1) begin
            slot0 <= din;
          end else begin
            slot0 <= slot1;
            slot1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign count = cnt_q;
  assign head  = slot0;

endmodule

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: three FU result FIFOs drained onto two CDB slots and per-unit RF write ports, 1 cycle min latency.
// Ready = own FIFO not full (registered count only), forced low during flush and reset.
module writeback_arbiter
  import ooo_types::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [PHYS_REG_BITS-1:0] alu_preg,
  input  logic [31:0]              alu_data,
  input  logic [ROB_IDX_BITS-1:0]  alu_rob,
  input  logic                     branch_valid,
  output logic                     branch_ready,
  input  logic [PHYS_REG_BITS-1:0] branch_preg,
  input  logic [31:0]              branch_data,
  input  logic [ROB_IDX_BITS-1:0]  branch_rob,
  input  logic                     lsu_valid,
  output logic                     lsu_ready,
  input  logic [PHYS_REG_BITS-1:0] lsu_preg,
  input  logic [31:0]              lsu_data,
  input  logic [ROB_IDX_BITS-1:0]  lsu_rob,
  input  logic                     flush,
  output logic                     we_alu,
  output logic [PHYS_REG_BITS-1:0] wa_alu,
  output logic [31:0]              wd_alu,
  output logic                     we_branch,
  output logic [PHYS_REG_BITS-1:0] wa_branch,
  output logic [31:0]              wd_branch,
  output logic                     we_lsu,
  output logic [PHYS_REG_BITS-1:0] wa_lsu,
  output logic [31:0]              wd_lsu,
  output logic                     cdb0_valid,
  output logic [PHYS_REG_BITS-1:0] cdb0_preg,
  output logic [ROB_IDX_BITS-1:0]  cdb0_rob,
  output logic                     cdb1_valid,
  output logic [PHYS_REG_BITS-1:0] cdb1_preg,
  output logic [ROB_IDX_BITS-1:0]  cdb1_rob
);

  localparam int NSRC = 3;

  logic                     active;
  logic [NSRC-1:0]          src_vld;
  logic [NSRC-1:0]          src_rdy;
  logic [NSRC-1:0]          push;
  logic [NSRC-1:0]          nonempty;
  logic [NSRC-1:0]          gnt;
  logic [NSRC-1:0]          we;
  wb_entry_t                src_ent [NSRC];
  wb_entry_t                head    [NSRC];
  logic [1:0]               cnt     [NSRC];
  logic [PHYS_REG_BITS-1:0] wa      [NSRC];
  logic [31:0]              wd      [NSRC];
  logic [1:0]               rr;
  logic [1:0]               idx;

  assign active  = rst_n && !flush;
  assign src_vld = {lsu_valid, branch_valid, alu_valid};

  assign src_ent[SRC_ALU]    = '{preg: alu_preg,    data: alu_data,    rob: alu_rob};
  assign src_ent[SRC_BRANCH] = '{preg: branch_preg, data: branch_data, rob: branch_rob};
  assign src_ent[SRC_LSU]    = '{preg: lsu_preg,    data: lsu_data,    rob: lsu_rob};

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    assign src_rdy[i]  = active && (cnt[i] != 2'd2);
    assign push[i]     = src_vld[i] && src_rdy[i];
    assign nonempty[i] = active && (cnt[i] != 2'd0);

    wb_fifo u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[i]),
      .pop   (gnt[i]),
      .flush (flush),
      .din   (src_ent[i]),
      .count (cnt[i]),
      .head  (head[i])
    );

    // x0 results still complete in the ROB via the CDB but never touch the RF
    assign we[i] = gnt[i] && (head[i].preg != '0);
    assign wa[i] = we[i] ? head[i].preg : '0;
    assign wd[i] = we[i] ? head[i].data : '0;
  end

  // Walk priority order rr, rr+1, rr+2 filling cdb0 then cdb1.
  always_comb begin
    gnt        = '0;
    idx        = 2'd0;
    cdb0_valid = 1'b0;
    cdb0_preg  = '0;
    cdb0_rob   = '0;
    cdb1_valid = 1'b0;
    cdb1_preg  = '0;
    cdb1_rob   = '0;
    for (int k = 0; k < NSRC; k++) begin
      idx = rr_add(rr, 2'(k));
      if (nonempty[idx]) begin
        if (!cdb0_valid) begin
          gnt[idx]   = 1'b1;
          cdb0_valid = 1'b1;
          cdb0_preg  = head[idx].preg;
          cdb0_rob   = head[idx].rob;
        end else if (!cdb1_valid) begin
          gnt[idx]   = 1'b1;
          cdb1_valid = 1'b1;
          cdb1_preg  = head[idx].preg;
          cdb1_rob   = head[idx].rob;
        end
      end
    end
  end

  // Only a three-way contention leaves a loser, which then leads next cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) rr <= 2'd0;
    else if (&nonempty) rr <= rr_add(rr, 2'd2);
  end

  assign alu_ready    = src_rdy[SRC_ALU];
  assign branch_ready = src_rdy[SRC_BRANCH];
  assign lsu_ready    = src_rdy[SRC_LSU];

  assign we_alu    = we[SRC_ALU];
  assign wa_alu    = wa[SRC_ALU];
  assign wd_alu    = wd[SRC_ALU];
  assign we_branch = we[SRC_BRANCH];
  assign wa_branch = wa[SRC_BRANCH];
  assign wd_branch = wd[SRC_BRANCH];
  assign we_lsu    = we[SRC_LSU];
  assign wa_lsu    = wa[SRC_LSU];
  assign wd_lsu    = wd[SRC_LSU];

  a_unique_dest: assert property (@(posedge clk) disable iff (!rst_n)
    (cdb0_valid && cdb1_valid && (cdb0_preg != '0)) |-> (cdb0_preg != cdb1_preg));

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: directed vector table, hand-written corner sequences, and random traffic vs a queue model.
module tb_writeback_arbiter;
  import ooo_types::*;

  localparam int PB = PHYS_REG_BITS;
  localparam int RB = ROB_IDX_BITS;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          flush;
  logic [2:0]    v;
  logic [PB-1:0] p [3];
  logic [RB-1:0] r [3];
  logic [31:0]   d [3];

  wire [2:0]    rdy;
  wire [2:0]    we;
  wire [PB-1:0] wa [3];
  wire [31:0]   wd [3];
  wire          c0v, c1v;
  wire [PB-1:0] c0p, c1p;
  wire [RB-1:0] c0r, c1r;

  writeback_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(v[0]), .alu_ready(rdy[0]), .alu_preg(p[0]), .alu_data(d[0]), .alu_rob(r[0]),
    .branch_valid(v[1]), .branch_ready(rdy[1]), .branch_preg(p[1]), .branch_data(d[1]), .branch_rob(r[1]),
    .lsu_valid(v[2]), .lsu_ready(rdy[2]), .lsu_preg(p[2]), .lsu_data(d[2]), .lsu_rob(r[2]),
    .flush(flush),
    .we_alu(we[0]), .wa_alu(wa[0]), .wd_alu(wd[0]),
    .we_branch(we[1]), .wa_branch(wa[1]), .wd_branch(wd[1]),
    .we_lsu(we[2]), .wa_lsu(wa[2]), .wd_lsu(wd[2]),
    .cdb0_valid(c0v), .cdb0_preg(c0p), .cdb0_rob(c0r),
    .cdb1_valid(c1v), .cdb1_preg(c1p), .cdb1_rob(c1r)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit rand_mode = 1'b0;
  bit collect   = 1'b0;
  int seen_lsu [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Data is tied to preg so an expected write address also fixes the expected write data.
  function automatic logic [31:0] dat_of(input logic [PB-1:0] preg);
    return 32'hDEAD_BEEF ^ 32'(preg ^ PB'(5));
  endfunction

  task automatic set_src(input int s, input bit vv, input int preg, input int rob);
    v[s] = vv;
    p[s] = PB'(preg);
    r[s] = RB'(rob);
    d[s] = dat_of(PB'(preg));
  endtask

  task automatic idle();
    for (int s = 0; s < 3; s++) set_src(s, 1'b0, 0, 0);
  endtask

  // ---------------- reference model: one queue per source plus a pointer ----------------
  wb_entry_t     mq [3][$];
  int            mrr = 0;
  bit            all3;
  logic [2:0]    e_rdy, e_we, e_pop;
  logic [PB-1:0] e_wa [3];
  logic [31:0]   e_wd [3];
  logic          e_c0v, e_c1v;
  logic [PB-1:0] e_c0p, e_c1p;
  logic [RB-1:0] e_c0r, e_c1r;

  task automatic model_eval();
    bit act;
    int ne [$];
    int ord [$];
    int tmp;
    wb_entry_t e;
    act = (rst_n === 1'b1) && (flush === 1'b0);
    e_rdy = '0; e_we = '0; e_pop = '0;
    e_c0v = 1'b0; e_c0p = '0; e_c0r = '0;
    e_c1v = 1'b0; e_c1p = '0; e_c1r = '0;
    for (int s = 0; s < 3; s++) begin
      e_wa[s] = '0;
      e_wd[s] = '0;
      if (act && mq[s].size() < 2) e_rdy[s] = 1'b1;
      if (act && mq[s].size() > 0) ne.push_back(s);
    end
    all3 = (ne.size() == 3);
    if (all3) begin
      ord.push_back(mrr);
      ord.push_back((mrr + 1) % 3);
    end else begin
      ord = ne;
      if (ord.size() == 2 && ((ord[1] - mrr + 3) % 3) < ((ord[0] - mrr + 3) % 3)) begin
        tmp = ord[0]; ord[0] = ord[1]; ord[1] = tmp;
      end
    end
    for (int i = 0; i < ord.size(); i++) begin
      e = mq[ord[i]][0];
      e_pop[ord[i]] = 1'b1;
      if (e.preg != '0) begin
        e_we[ord[i]] = 1'b1;
        e_wa[ord[i]] = e.preg;
        e_wd[ord[i]] = e.data;
      end
      if (i == 0) begin e_c0v = 1'b1; e_c0p = e.preg; e_c0r = e.rob; end
      else        begin e_c1v = 1'b1; e_c1p = e.preg; e_c1r = e.rob; end
    end
  endtask

  task automatic model_update();
    if (rst_n !== 1'b1 || flush === 1'b1) begin
      for (int s = 0; s < 3; s++) mq[s].delete();
      if (rst_n !== 1'b1) mrr = 0;
    end else begin
      for (int s = 0; s < 3; s++) if (e_pop[s]) void'(mq[s].pop_front());
      for (int s = 0; s < 3; s++)
        if (v[s] && e_rdy[s]) mq[s].push_back('{preg: p[s], data: d[s], rob: r[s]});
      if (all3) mrr = (mrr + 2) % 3;
    end
  endtask

  task automatic model_cmp();
    chk("rnd rdy", 32'(rdy), 32'(e_rdy));
    chk("rnd we", 32'(we), 32'(e_we));
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("rnd wa%0d", s), 32'(wa[s]), 32'(e_wa[s]));
      chk($sformatf("rnd wd%0d", s), wd[s], e_wd[s]);
    end
    chk("rnd cdb0", {c0v, 8'(c0p), 8'(c0r)}, {e_c0v, 8'(e_c0p), 8'(e_c0r)});
    chk("rnd cdb1", {c1v, 8'(c1p), 8'(c1r)}, {e_c1v, 8'(e_c1p), 8'(e_c1r)});
  endtask

  // Inputs are driven just after posedge; outputs are sampled at the following negedge.
  task automatic settle();
    @(negedge clk);
    model_eval();
    if (collect) begin
      if (c0v && c0p >= PB'(40) && c0p <= PB'(42)) seen_lsu.push_back(int'(c0p));
      if (c1v && c1p >= PB'(40) && c1p <= PB'(42)) seen_lsu.push_back(int'(c1p));
    end
  endtask

  task automatic advance();
    if (rand_mode) model_cmp();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; flush = 1'b0; idle();
    settle(); advance();
    rst_n = 1'b1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic                rst_n, flush;
    logic [2:0]          v;
    logic [2:0][PB-1:0]  p;
    logic [2:0][RB-1:0]  r;
    logic [2:0]          e_rdy;
    logic [2:0][PB-1:0]  e_wa;
    logic                e_c0v;
    logic [PB-1:0]       e_c0p;
    logic [RB-1:0]       e_c0r;
    logic                e_c1v;
    logic [PB-1:0]       e_c1p;
    logic [RB-1:0]       e_c1r;
  } vec_t;

  vec_t vt [$];

  task automatic add_vec(input int rs, input int fl, input int vv,
                         input int pa, input int pb, input int pl,
                         input int ra, input int rb, input int rl, input int erdy,
                         input int wa_a, input int wa_b, input int wa_l,
                         input int c0, input int c0pp, input int c0rr,
                         input int c1, input int c1pp, input int c1rr);
    vec_t x;
    x.rst_n = 1'(rs); x.flush = 1'(fl); x.v = 3'(vv);
    x.p = {PB'(pl), PB'(pb), PB'(pa)};
    x.r = {RB'(rl), RB'(rb), RB'(ra)};
    x.e_rdy = 3'(erdy);
    x.e_wa = {PB'(wa_l), PB'(wa_b), PB'(wa_a)};
    x.e_c0v = 1'(c0); x.e_c0p = PB'(c0pp); x.e_c0r = RB'(c0rr);
    x.e_c1v = 1'(c1); x.e_c1p = PB'(c1pp); x.e_c1r = RB'(c1rr);
    vt.push_back(x);
  endtask

  logic ewe;
  int   nxt_preg = 0;

  initial begin
    rst_n = 1'b0; flush = 1'b0; idle();
    @(posedge clk); #1;

    //       rst fl v      pa  pb  pl  ra rb rl  rdy    wa a  b  l   cdb0         cdb1
    add_vec(0, 0, 3'b000,  0,  0,  0,  0, 0, 0,  3'b000, 0, 0, 0,  0,  0, 0,   0,  0, 0);
    add_vec(0, 0, 3'b111,  9,  9,  9,  1, 1, 1,  3'b000, 0, 0, 0,  0,  0, 0,   0,  0, 0);
    add_vec(1, 0, 3'b001,  5,  0,  0,  3, 0, 0,  3'b111, 0, 0, 0,  0,  0, 0,   0,  0, 0);
    add_vec(1, 0, 3'b000,  0,  0,  0,  0, 0, 0,  3'b111, 5, 0, 0,  1,  5, 3,   0,  0, 0);
    add_vec(1, 0, 3'b111, 10, 11, 12,  1, 2, 4,  3'b111, 0, 0, 0,  0,  0, 0,   0,  0, 0);
    add_vec(1, 0, 3'b000,  0,  0,  0,  0, 0, 0,  3'b111,10,11, 0,  1, 10, 1,   1, 11, 2);
    add_vec(1, 0, 3'b000,  0,  0,  0,  0, 0, 0,  3'b111, 0, 0,12,  1, 12, 4,   0,  0, 0);
    add_vec(1, 0, 3'b111, 20, 21, 22,  5, 6, 7,  3'b111, 0, 0, 0,  0,  0, 0,   0,  0, 0);
    add_vec(1, 0, 3'b000,  0,  0,  0,  0, 0, 0,  3'b111,20, 0,22,  1, 22, 7,   1, 20, 5);
    add_vec(1, 0, 3'b000,  0,  0,  0,  0, 0, 0,  3'b111, 0,21, 0,  1, 21, 6,   0,  0, 0);
    add_vec(1, 0, 3'b010,  0,  0,  0,  0, 7, 0,  3'b111, 0, 0, 0,  0,  0, 0,   0,  0, 0);
    add_vec(1, 0, 3'b000,  0,  0,  0,  0, 0, 0,  3'b111, 0, 0, 0,  1,  0, 7,   0,  0, 0);
    add_vec(1, 0, 3'b111, 30, 31, 32,  8, 9,10,  3'b111, 0, 0, 0,  0,  0, 0,   0,  0, 0);
    add_vec(1, 0, 3'b000,  0,  0,  0,  0, 0, 0,  3'b111, 0,31,32,  1, 31, 9,   1, 32,10);
    add_vec(1, 0, 3'b000,  0,  0,  0,  0, 0, 0,  3'b111,30, 0, 0,  1, 30, 8,   0,  0, 0);

    for (int i = 0; i < vt.size(); i++) begin
      rst_n = vt[i].rst_n;
      flush = vt[i].flush;
      for (int s = 0; s < 3; s++) set_src(s, vt[i].v[s], int'(vt[i].p[s]), int'(vt[i].r[s]));
      settle();
      chk($sformatf("vec%0d rdy", i), 32'(rdy), 32'(vt[i].e_rdy));
      for (int s = 0; s < 3; s++) begin
        ewe = (vt[i].e_wa[s] != '0);
        chk($sformatf("vec%0d we%0d", i, s), 32'(we[s]), 32'(ewe));
        chk($sformatf("vec%0d wa%0d", i, s), 32'(wa[s]), 32'(vt[i].e_wa[s]));
        chk($sformatf("vec%0d wd%0d", i, s), wd[s], ewe ? dat_of(vt[i].e_wa[s]) : 32'd0);
      end
      chk($sformatf("vec%0d cdb0", i), {c0v, 8'(c0p), 8'(c0r)},
          {vt[i].e_c0v, 8'(vt[i].e_c0p), 8'(vt[i].e_c0r)});
      chk($sformatf("vec%0d cdb1", i), {c1v, 8'(c1p), 8'(c1r)},
          {vt[i].e_c1v, 8'(vt[i].e_c1p), 8'(vt[i].e_c1r)});
      advance();
    end

    // ---- back-pressure: lsu loses to alu/branch, fills, then drains in order ----
    do_reset();
    collect = 1'b1;
    set_src(0, 1, 50, 1); set_src(1, 1, 55, 2); set_src(2, 1, 40, 3);
    settle(); chk("bp c0 lsu_ready", 32'(rdy[2]), 32'd1); advance();
    set_src(0, 1, 51, 4); set_src(1, 1, 56, 5); set_src(2, 1, 41, 6);
    settle();
    chk("bp c1 lsu_ready", 32'(rdy[2]), 32'd1);
    chk("bp c1 cdb0", 32'(c0p), 32'd50);
    chk("bp c1 cdb1", 32'(c1p), 32'd55);
    advance();
    set_src(0, 1, 52, 7); set_src(1, 1, 57, 8); set_src(2, 1, 42, 9);
    settle();
    chk("bp c2 lsu_ready full", 32'(rdy[2]), 32'd0);
    chk("bp c2 cdb0 lsu", 32'(c0p), 32'd40);
    advance();
    idle(); set_src(2, 1, 42, 9);
    settle(); chk("bp c3 lsu_ready back", 32'(rdy[2]), 32'd1); advance();
    idle();
    for (int i = 0; i < 8; i++) begin settle(); advance(); end
    collect = 1'b0;
    chk("bp lsu count", 32'(seen_lsu.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("bp lsu order%0d", i), (i < seen_lsu.size()) ? 32'(seen_lsu[i]) : 32'hFFFF, 32'(40 + i));

    // ---- flush with all FIFOs occupied ----
    do_reset();
    for (int k = 0; k < 4; k++) begin
      for (int s = 0; s < 3; s++) set_src(s, 1, 1 + 3 * k + s, k);
      settle(); advance();
    end
    flush = 1'b1;
    for (int s = 0; s < 3; s++) set_src(s, 1, 20 + s, 1);
    settle();
    chk("fl we", 32'(we), 32'd0);
    chk("fl cdb", {31'd0, c0v | c1v}, 32'd0);
    chk("fl rdy", 32'(rdy), 32'd0);
    advance();
    flush = 1'b0; idle();
    settle();
    chk("fl next rdy", 32'(rdy), 32'b111);
    chk("fl next cdb", {31'd0, c0v | c1v}, 32'd0);
    advance();
    for (int i = 0; i < 3; i++) begin
      settle();
      chk($sformatf("fl stale%0d", i), {30'd0, c0v, c1v}, 32'd0);
      advance();
    end

    // ---- reset mid-stream with rr moved away from 0 ----
    do_reset();
    for (int k = 0; k < 3; k++) begin
      for (int s = 0; s < 3; s++) set_src(s, 1, 1 + 3 * k + s, k);
      settle(); advance();
    end
    rst_n = 1'b0;
    for (int s = 0; s < 3; s++) set_src(s, 1, 20 + s, 2);
    settle();
    chk("rs rdy", 32'(rdy), 32'd0);
    chk("rs we", 32'(we), 32'd0);
    chk("rs cdb", {c0v, 8'(c0p), 8'(c0r), c1v, 8'(c1p), 6'(c1r)}, 32'd0);
    for (int s = 0; s < 3; s++) chk($sformatf("rs wa/wd%0d", s), wd[s] | 32'(wa[s]), 32'd0);
    advance();
    rst_n = 1'b1;
    for (int s = 0; s < 3; s++) set_src(s, 1, 30 + s, 1 + s);
    settle();
    chk("rs after rdy", 32'(rdy), 32'b111);
    chk("rs after cdb", {31'd0, c0v}, 32'd0);
    advance();
    idle();
    settle();
    chk("rs rr0 cdb0", 32'(c0p), 32'd30);
    chk("rs rr0 cdb1", 32'(c1p), 32'd31);
    advance();

    // ---- random traffic against the queue model ----
    do_reset();
    rand_mode = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom % 64) != 0;
      flush = ($urandom % 24) == 0;
      for (int s = 0; s < 3; s++) begin
        if (($urandom % 5) < 3) begin
          nxt_preg = (nxt_preg >= 63) ? 1 : nxt_preg + 1;
          set_src(s, 1, (($urandom % 8) == 0) ? 0 : nxt_preg, int'($urandom % 32));
        end else begin
          set_src(s, 0, 0, 0);
        end
      end
      settle();
      advance();
    end
    rand_mode = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
